// File: rtl/led_pkg.sv
// Shared types for the LED scan path: array geometry, index/row types and the scan FSM encoding.
package led_pkg;

    localparam int LED_COLS = 8;
    localparam int LED_ROWS = 8;

    typedef logic [2:0]          col_idx_t;
    typedef logic [LED_ROWS-1:0] row_bits_t;
    typedef logic [LED_COLS-1:0] col_bits_t;

    typedef enum logic {
        S_BLANK = 1'b0,
        S_ON    = 1'b1
    } scan_state_t;

    function automatic col_bits_t col_onehot(input col_idx_t c);
        return col_bits_t'(1) << c;
    endfunction

endpackage

// File: rtl/led_frame_buf.sv
// Double-buffered 8x8 frame store: writes always go to the back bank, reads always come from the
// front bank, and i_toggle exchanges the two roles on the next clock edge.
module led_frame_buf
    import led_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst,
    input  logic      i_wr_en,
    input  col_idx_t  i_wr_col,
    input  row_bits_t i_wr_data,
    input  logic      i_toggle,
    input  col_idx_t  i_rd_col,
    output row_bits_t o_rd_data
);

    row_bits_t r_bank [2][LED_COLS];
    logic      r_sel;
    logic      w_back;

    assign w_back = ~r_sel;

    // The write uses the select from before the edge, so a write on the toggle cycle lands in
    // the bank that is about to become the front.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int b = 0; b < 2; b++) begin
                for (int c = 0; c < LED_COLS; c++) begin
                    r_bank[b][c] <= '0;
                end
            end
            r_sel <= 1'b0;
        end else begin
            if (i_wr_en) begin
                r_bank[w_back][i_wr_col] <= i_wr_data;
            end
            if (i_toggle) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign o_rd_data = r_bank[r_sel][i_rd_col];

endmodule

// File: rtl/led_scan_driver.sv
// Column-scanning driver for an 8x8 LED array: dwell counter, blank/on FSM, swap handshake and
// registered pin outputs in front of a double-buffered frame store.
module led_scan_driver
    import led_pkg::*;
#(
    parameter int DWELL     = 1000,
    parameter int BLANK_CYC = 16
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        WR_EN,
    input  col_idx_t    WR_COL,
    input  row_bits_t   WR_DATA,
    input  logic        SWAP_REQ,
    output logic        SWAP_ACK,
    output col_idx_t    COL_SEL,
    output col_bits_t   COL_EN,
    output row_bits_t   ROW_DATA,
    output logic        BLANK,
    output scan_state_t DBG_STATE
);

    localparam int             CW            = $clog2(DWELL);
    localparam logic [CW-1:0]  CNT_LAST      = CW'(DWELL - 1);
    localparam logic [CW-1:0]  CNT_BLANK_END = CW'(BLANK_CYC - 1);

    generate
        if (!(DWELL > BLANK_CYC && BLANK_CYC >= 1)) begin : g_param_check
            $error("led_scan_driver: need DWELL > BLANK_CYC >= 1");
        end
    endgenerate

    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    col_idx_t      r_col;
    col_idx_t      w_col_nxt;
    scan_state_t   r_state;
    scan_state_t   w_state_nxt;
    logic          r_pend;
    logic          w_wrap;
    logic          w_boundary;
    logic          w_swap;
    row_bits_t     w_front_row;

    logic          r_swap_ack;
    col_idx_t      r_col_sel;
    col_bits_t     r_col_en;
    row_bits_t     r_row_data;
    logic          r_blank;

    // Swap handshake: SWAP_REQ is a level/pulse request with no ready; it is latched into r_pend
    // and consumed at the next frame boundary (cnt at its last value on column 7). A request seen
    // on the boundary cycle itself is consumed there. SWAP_ACK pulses for the one cycle where the
    // new front bank and column 0 become current.
    assign w_wrap     = (r_cnt == CNT_LAST);
    assign w_boundary = w_wrap && (r_col == col_idx_t'(LED_COLS - 1));
    assign w_swap     = w_boundary && (r_pend || SWAP_REQ);

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = w_wrap ? '0 : r_cnt + CW'(1);
        w_col_nxt   = w_wrap ? r_col + 3'd1 : r_col;
        case (r_state)
            S_BLANK: if (r_cnt == CNT_BLANK_END) w_state_nxt = S_ON;
            S_ON:    if (w_wrap)                 w_state_nxt = S_BLANK;
            default: w_state_nxt = S_BLANK;
        endcase
    end

    led_frame_buf u_frame_buf (
        .i_clk     (CLK),
        .i_rst     (RESET),
        .i_wr_en   (WR_EN),
        .i_wr_col  (WR_COL),
        .i_wr_data (WR_DATA),
        .i_toggle  (w_swap),
        .i_rd_col  (w_col_nxt),
        .o_rd_data (w_front_row)
    );

    // Pins are registered from next-state values so they line up with r_state/r_col exactly.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_cnt      <= '0;
            r_col      <= '0;
            r_state    <= S_BLANK;
            r_pend     <= 1'b0;
            r_swap_ack <= 1'b0;
            r_col_sel  <= '0;
            r_col_en   <= '0;
            r_row_data <= '0;
            r_blank    <= 1'b1;
        end else begin
            r_cnt      <= w_cnt_nxt;
            r_col      <= w_col_nxt;
            r_state    <= w_state_nxt;
            r_pend     <= w_boundary ? 1'b0 : (r_pend || SWAP_REQ);
            r_swap_ack <= w_swap;
            r_col_sel  <= w_col_nxt;
            r_col_en   <= (w_state_nxt == S_ON) ? col_onehot(w_col_nxt) : '0;
            r_row_data <= (w_state_nxt == S_ON) ? w_front_row : '0;
            r_blank    <= (w_state_nxt == S_BLANK);
        end
    end

    assign SWAP_ACK  = r_swap_ack;
    assign COL_SEL   = r_col_sel;
    assign COL_EN    = r_col_en;
    assign ROW_DATA  = r_row_data;
    assign BLANK     = r_blank;
    assign DBG_STATE = r_state;

endmodule

// File: tb/tb_led_scan_driver.sv
// Bench for led_scan_driver with DWELL=8, BLANK_CYC=2: table vectors, directed swap/reset
// sequences and random traffic against a cycle-count based reference model.
module tb_led_scan_driver;
    import led_pkg::*;

    localparam int DWELL     = 8;
    localparam int BLANK_CYC = 2;
    localparam int FRAME     = DWELL * 8;

    logic        CLK      = 1'b0;
    logic        RESET    = 1'b1;
    logic        WR_EN    = 1'b0;
    logic [2:0]  WR_COL   = '0;
    logic [7:0]  WR_DATA  = '0;
    logic        SWAP_REQ = 1'b0;
    logic        SWAP_ACK;
    logic [2:0]  COL_SEL;
    logic [7:0]  COL_EN;
    logic [7:0]  ROW_DATA;
    logic        BLANK;
    scan_state_t DBG_STATE;

    led_scan_driver #(.DWELL(DWELL), .BLANK_CYC(BLANK_CYC)) dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .WR_EN     (WR_EN),
        .WR_COL    (WR_COL),
        .WR_DATA   (WR_DATA),
        .SWAP_REQ  (SWAP_REQ),
        .SWAP_ACK  (SWAP_ACK),
        .COL_SEL   (COL_SEL),
        .COL_EN    (COL_EN),
        .ROW_DATA  (ROW_DATA),
        .BLANK     (BLANK),
        .DBG_STATE (DBG_STATE)
    );

    always #5 CLK = ~CLK;

    int         n_vec;
    int         n_mis;
    int         ack_cnt;
    // Reference model: k = clock edges since reset release; everything visible derives from k.
    int         k;
    int         m_sel;
    bit         m_pend;
    bit         m_ack;
    logic [7:0] m_bank [2][8];

    typedef struct {
        logic [2:0] sel;
        logic [7:0] en;
        logic       blank;
    } vec_t;
    vec_t tbl [12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s k=%0d act=%h exp=%h", name, k, act, exp);
        end
    endtask

    task automatic model_reset();
        k      = 0;
        m_sel  = 0;
        m_pend = 1'b0;
        m_ack  = 1'b0;
        for (int b = 0; b < 2; b++)
            for (int c = 0; c < 8; c++)
                m_bank[b][c] = 8'h00;
    endtask

    task automatic model_edge();
        if (WR_EN) m_bank[1 - m_sel][WR_COL] = WR_DATA;
        m_ack = 1'b0;
        if (k % FRAME == FRAME - 1) begin
            if (m_pend || SWAP_REQ) begin
                m_sel  = 1 - m_sel;
                m_pend = 1'b0;
                m_ack  = 1'b1;
            end
        end else if (SWAP_REQ) begin
            m_pend = 1'b1;
        end
        k++;
    endtask

    task automatic check_model(input string name);
        int         ph;
        int         c;
        bit         bl;
        logic [7:0] en;
        logic [7:0] row;
        ph  = k % DWELL;
        c   = (k / DWELL) % 8;
        bl  = (ph < BLANK_CYC);
        en  = bl ? 8'h00 : 8'(1 << c);
        row = bl ? 8'h00 : m_bank[m_sel][c];
        check(name, {11'd0, COL_SEL, COL_EN, ROW_DATA, BLANK, SWAP_ACK},
                    {11'd0, 3'(c), en, row, bl, m_ack});
    endtask

    task automatic step(input string name);
        @(posedge CLK);
        model_edge();
        #1;
        check_model(name);
        if (SWAP_ACK) ack_cnt++;
    endtask

    task automatic check_reset_pins(input string name);
        check(name, {11'd0, COL_SEL, COL_EN, ROW_DATA, BLANK, SWAP_ACK},
                    {11'd0, 3'd0, 8'h00, 8'h00, 1'b1, 1'b0});
    endtask

    initial begin
        n_vec   = 0;
        n_mis   = 0;
        ack_cnt = 0;
        model_reset();

        tbl[0]  = '{3'd0, 8'h00, 1'b1};
        tbl[1]  = '{3'd0, 8'h01, 1'b0};
        tbl[2]  = '{3'd0, 8'h01, 1'b0};
        tbl[3]  = '{3'd0, 8'h01, 1'b0};
        tbl[4]  = '{3'd0, 8'h01, 1'b0};
        tbl[5]  = '{3'd0, 8'h01, 1'b0};
        tbl[6]  = '{3'd0, 8'h01, 1'b0};
        tbl[7]  = '{3'd1, 8'h00, 1'b1};
        tbl[8]  = '{3'd1, 8'h00, 1'b1};
        tbl[9]  = '{3'd1, 8'h02, 1'b0};
        tbl[10] = '{3'd1, 8'h02, 1'b0};
        tbl[11] = '{3'd1, 8'h02, 1'b0};

        // Reset held for three cycles.
        repeat (3) @(posedge CLK);
        #1;
        check_reset_pins("reset_state");
        RESET = 1'b0;
        model_reset();

        // First column after release, from the table.
        for (int i = 0; i < 12; i++) begin
            step("table_model");
            check("table_pins", {20'd0, COL_SEL, COL_EN, BLANK},
                                {20'd0, tbl[i].sel, tbl[i].en, tbl[i].blank});
        end

        // Free-run scan order with one-hot and blank-exclusion invariants.
        for (int i = 0; i < FRAME; i++) begin
            step("scan_order");
            check("onehot", {31'd0, ($countones(COL_EN) <= 1)}, 32'd1);
            check("blank_excl", {31'd0, (BLANK && (COL_EN != 8'h00))}, 32'd0);
        end

        // Back-bank write to column 3 must not reach the display without a swap.
        WR_EN = 1'b1; WR_COL = 3'd3; WR_DATA = 8'hFF;
        step("iso_write");
        WR_EN = 1'b0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step("isolation");
            if (COL_SEL == 3'd3 && !BLANK) check("iso_col3", {24'd0, ROW_DATA}, 32'h00);
        end

        // Fill back bank, request swap mid-frame, expect one ack at the boundary.
        for (int c = 0; c < 8; c++) begin
            WR_EN = 1'b1; WR_COL = 3'(c); WR_DATA = 8'hA0 | 8'(c);
            step("fill");
        end
        WR_EN = 1'b0;
        for (int i = 0; i < FRAME && (k % FRAME) != 30; i++) step("to_mid");
        ack_cnt  = 0;
        SWAP_REQ = 1'b1;
        step("swap_req");
        SWAP_REQ = 1'b0;
        for (int i = 0; i < FRAME && (k % FRAME) != 0; i++) step("to_boundary");
        check("swap_ack_at_col0", {31'd0, SWAP_ACK}, 32'd1);
        for (int i = 0; i < FRAME; i++) begin
            step("new_frame");
            if (!BLANK) check("new_frame_row", {24'd0, ROW_DATA}, {24'd0, 8'hA0 | 8'(COL_SEL)});
        end
        check("swap_ack_once", ack_cnt, 32'd1);

        // Request only on the boundary cycle itself.
        for (int i = 0; i < FRAME && (k % FRAME) != FRAME - 1; i++) step("to_last");
        SWAP_REQ = 1'b1;
        step("bnd_req");
        SWAP_REQ = 1'b0;
        check("bnd_ack", {31'd0, SWAP_ACK}, 32'd1);

        // Three requests in one frame merge into a single swap.
        ack_cnt = 0;
        for (int t = 10; t <= 30; t += 10) begin
            for (int i = 0; i < FRAME && (k % FRAME) != t; i++) step("to_req");
            SWAP_REQ = 1'b1;
            step("multi_req");
            SWAP_REQ = 1'b0;
        end
        for (int i = 0; i < FRAME && (k % FRAME) != 1; i++) step("to_merge_end");
        check("merged_ack", ack_cnt, 32'd1);

        // Mid-frame reset at column 5 with a swap pending.
        for (int i = 0; i < FRAME && (k % FRAME) != 16; i++) step("to_col2");
        SWAP_REQ = 1'b1;
        step("pend_req");
        SWAP_REQ = 1'b0;
        for (int i = 0; i < FRAME && (k % FRAME) != 43; i++) step("to_col5");
        #2 RESET = 1'b1;
        #1;
        check_reset_pins("async_reset");
        repeat (2) @(posedge CLK);
        #1;
        check_reset_pins("reset_held");
        RESET = 1'b0;
        model_reset();
        ack_cnt = 0;
        for (int i = 0; i < 2 * FRAME; i++) begin
            step("post_reset");
            if (!BLANK) check("post_reset_row", {24'd0, ROW_DATA}, 32'h00);
        end
        check("no_ack_after_reset", ack_cnt, 32'd0);

        // Random writes and swap requests.
        for (int i = 0; i < 800; i++) begin
            WR_EN    = 1'($urandom_range(0, 1));
            WR_COL   = 3'($urandom_range(0, 7));
            WR_DATA  = 8'($urandom);
            SWAP_REQ = ($urandom_range(0, 15) == 0);
            step("random");
        end
        WR_EN    = 1'b0;
        SWAP_REQ = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule
